// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder / bit_serial_adder
// Brief    : Single-bit full adder cell and the LSB-first sequencer that
//            streams two WIDTH-bit operands through it, one bit per clock.
// Revision : 1.0
// ============================================================================

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_cin;
    assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din_A,
    input  logic [WIDTH-1:0] din_B,
    input  logic             din_cin,
    output logic             dout_ready,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout_sum,
    output logic             dout_carry
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PS_W  = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sr_a;
    logic [WIDTH-1:0]   r_sr_b;
    logic [PS_W-1:0]    r_sr_s;
    logic               r_carry_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dout_valid;
    logic [WIDTH-1:0]   r_dout_sum;
    logic               r_dout_carry;

    logic               w_fa_sum;
    logic               w_fa_carry;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_next;
    logic [PS_W-1:0]    w_ps_next;

    full_adder u_fa (
        .i_a     (r_sr_a[0]),
        .i_b     (r_sr_b[0]),
        .i_cin   (r_carry_q),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_last = (r_cnt == c_last_bit);

    // Partial sum keeps only the upper WIDTH-1 bits; the newest bit comes
    // straight from the adder, so bit 0 of the shifted word never needs storage.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_next = w_fa_sum;
            assign w_ps_next  = 1'b0;
        end else begin : g_wn
            assign w_sum_next = {w_fa_sum, r_sr_s};
            assign w_ps_next  = w_sum_next[WIDTH-1:1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (din_valid) w_state_next = SHIFT;
            SHIFT:   if (w_last)    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_a       <= '0;
            r_sr_b       <= '0;
            r_sr_s       <= '0;
            r_carry_q    <= 1'b0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
            r_dout_sum   <= '0;
            r_dout_carry <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (din_valid) begin
                    r_sr_a    <= din_A;
                    r_sr_b    <= din_B;
                    r_carry_q <= din_cin;
                    r_cnt     <= '0;
                end
            end else begin
                r_sr_a    <= r_sr_a >> 1;
                r_sr_b    <= r_sr_b >> 1;
                r_sr_s    <= w_ps_next;
                r_carry_q <= w_fa_carry;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    r_dout_sum   <= w_sum_next;
                    r_dout_carry <= w_fa_carry;
                    r_dout_valid <= 1'b1;
                end
            end
        end
    end

    assign dout_ready = (r_state == IDLE);
    assign dout_valid = r_dout_valid;
    assign dout_sum   = r_dout_sum;
    assign dout_carry = r_dout_carry;

endmodule
`default_nettype wire

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequencing stage that feeds the team's single-bit full_adder cell.
- Accepts two WIDTH-bit operands plus carry-in. Streams them LSB-first through one internal full_adder instance, one bit per clock, with a registered carry loop.
- Returns the WIDTH-bit sum and carry-out.
- Area-minimal alternative to a ripple chain; sits between operand registers and the result consumer.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- din_valid  input  1  operand request; sampled only while dout_ready=1.
- din_A  input  WIDTH  operand A.
- din_B  input  WIDTH  operand B.
- din_cin  input  1  carry-in for bit 0.
- dout_ready  output  1  block idle, can accept operands.
- dout_valid  output  1  one-cycle pulse, result just completed.
- dout_sum  output  WIDTH  registered sum, held until next completion.
- dout_carry  output  1  registered carry-out of MSB, held until next completion.

Behaviour:

Reset:
- rst=1 asynchronously forces state=IDLE, dout_ready=1, dout_valid=0, dout_sum=0, dout_carry=0.
- Also clears the operand shift registers, partial-sum register, carry register and bit counter.
- Reset mid-operation discards the operation; no dout_valid is produced for it.

States: IDLE, SHIFT. dout_ready = (state==IDLE).

IDLE:
- On an edge with din_valid=1: load sr_A<=din_A, sr_B<=din_B, carry_q<=din_cin, cnt<=0, state<=SHIFT.
- That edge is the accept edge E0.

SHIFT:
- Full adder inputs: sr_A[0], sr_B[0], carry_q.
- Each edge:
  - sr_A and sr_B shift right by one.
  - sr_S<={fa_sum, sr_S[WIDTH-1:1]}.
  - carry_q<=fa_carry.
  - cnt<=cnt+1.
- On the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - dout_sum<={fa_sum, sr_S[WIDTH-1:1]} (for WIDTH=1: dout_sum<=fa_sum).
  - dout_carry<=fa_carry.
  - dout_valid<=1.
  - state<=IDLE.

Timing and throughput:
- Latency: dout_valid is high for exactly one cycle following edge E_WIDTH, i.e. WIDTH edges after acceptance.
- dout_ready is low from E0 until E_WIDTH, and high again in the same cycle dout_valid is high.
- A new din_valid in that cycle is accepted at edge E_WIDTH+1, giving back-to-back throughput of one result per WIDTH+1 cycles.
- dout_valid deasserts on the next edge unless another completion occurs.

Handshake and data rules:
- din_valid while dout_ready=0 is ignored (no queuing, no effect on the in-flight operation).
- din_A/din_B/din_cin may change freely after E0.

Arithmetic:
- {dout_carry, dout_sum} = din_A + din_B + din_cin, modulo 2^(WIDTH+1); unsigned, exact.
- Counter width: clog2(WIDTH), minimum 1 bit; no wrap occurs because the exit is at WIDTH-1.

Test Plan:
- WIDTH=8, A=0x5A, B=0x33, cin=0 -> after 8 edges dout_valid pulses one cycle, dout_sum=0x8D, dout_carry=0; dout_ready low for exactly 8 cycles.
- A=0xFF, B=0x01, cin=0 -> dout_sum=0x00, dout_carry=1 (full carry ripple through all bits).
- A=0xFF, B=0xFF, cin=1 -> dout_sum=0xFF, dout_carry=1; then A=0x00, B=0x00, cin=0 -> 0x00 / 0.
- Back-to-back: hold din_valid=1 with new operands (0x10+0x20, then 0x7F+0x01) -> second accepted in the dout_valid cycle; results 0x30/0 then 0x80/0, with valid pulses 9 cycles apart.
- din_valid pulsed with A=0xAA during cycle 3 of an operation -> ignored; in-flight result unchanged; dout_ready stays low.
- Assert rst at cycle 4 of an operation -> outputs immediately 0, dout_ready=1, no dout_valid; a fresh request afterwards computes correctly.
